// File: rtl/bubble_page_loader_pkg.sv
// bubble_page_loader_pkg: shared constants, state codes and address helper for the page loader
package bubble_page_loader_pkg;
  localparam int BOOT_BASE = 2053;
  localparam int BOOT_BYTES = 478;
  localparam int USER_BASE = 7168;
  localparam int USER_BYTES = 146;
  localparam int POS_LIMIT = 8190;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;
  localparam logic [2:0] ACC_BOOT = 3'b110;
  localparam logic [2:0] ACC_USER = 3'b111;
  localparam logic LT_BOOT = ACC_BOOT[0];
  localparam logic LT_USER = ACC_USER[0];
  function automatic logic [14:0] wr_addr(input logic [12:0] pos, input logic ch);
    return {1'b0, pos, ch};
  endfunction
endpackage

// File: rtl/bubble_page_loader_byte_serializer.sv
// bubble_page_loader_byte_serializer: byte shift register with one-deep holding register, MSB first
// Ports: clk/rst, clr (abort), fill/run (loader state), more (bytes left to request),
// din/din_valid/din_ready handshake, bit_out (current bit), last (final bit of byte),
// avail (a next byte is ready to follow without a gap), take (byte accepted this cycle).
module bubble_page_loader_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       fill,
  input  logic       run,
  input  logic       more,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       bit_out,
  output logic       last,
  output logic       avail,
  output logic       take
);
  logic [7:0] shift, hold;
  logic [2:0] cnt;
  logic hold_full;
  assign take = din_valid & din_ready & ~clr;
  assign last = run & (cnt == 3'd0);
  assign avail = hold_full | take;
  assign bit_out = shift[7];
  // din_ready is registered, so it drops for the cycle after a take to avoid a double accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      hold <= '0;
      cnt <= '0;
      hold_full <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      din_ready <= ~clr & ~take & (fill | (run & ~hold_full & more));
      hold_full <= ~clr & run & ~last & (hold_full | take);
      if (take) hold <= din;
      if (last ? avail : fill & take) begin
        shift <= hold_full ? hold : din;
        cnt <= 3'd7;
      end else if (run) begin
        shift <= {shift[6:0], 1'b0};
        cnt <= cnt - 3'd1;
      end
    end
  end
endmodule

// File: rtl/bubble_page_loader.sv
// bubble_page_loader: loads a boot image or user page byte stream into the bubble output buffer, one bit per cycle
// Ports: MCLK/RST, LOADSTART/LOADTYPE command, ABORT, DIN/DINVALID/DINREADY stream,
// nOUTBUFWCLKEN/OUTBUFWADDR/OUTBUFWDATA buffer write port, BUSY and DONE status.
module bubble_page_loader #(
  parameter int BOOT_BASE = bubble_page_loader_pkg::BOOT_BASE,
  parameter int BOOT_BYTES = bubble_page_loader_pkg::BOOT_BYTES,
  parameter int USER_BASE = bubble_page_loader_pkg::USER_BASE,
  parameter int USER_BYTES = bubble_page_loader_pkg::USER_BYTES
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        LOADSTART,
  input  logic        LOADTYPE,
  input  logic        ABORT,
  input  logic [7:0]  DIN,
  input  logic        DINVALID,
  output logic        DINREADY,
  output logic        nOUTBUFWCLKEN,
  output logic [14:0] OUTBUFWADDR,
  output logic        OUTBUFWDATA,
  output logic        BUSY,
  output logic        DONE
);
  import bubble_page_loader_pkg::*;
  logic [1:0] state;
  logic [13:0] pos;
  logic ch;
  logic [15:0] nreq, bytes_l;
  logic fill, run, more, bit_out, last, avail, take;
  assign fill = state == ST_FILL;
  assign run = state == ST_RUN;
  assign more = nreq < bytes_l;
  bubble_page_loader_byte_serializer u_ser (
    .clk(MCLK),
    .rst(RST),
    .clr(ABORT),
    .fill(fill),
    .run(run),
    .more(more),
    .din(DIN),
    .din_valid(DINVALID),
    .din_ready(DINREADY),
    .bit_out(bit_out),
    .last(last),
    .avail(avail),
    .take(take)
  );
  // pos is 14 bits wide so a page running past the top of the buffer stays above the guard instead of wrapping
  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      pos <= '0;
      ch <= 1'b0;
      nreq <= '0;
      bytes_l <= '0;
      nOUTBUFWCLKEN <= 1'b1;
      OUTBUFWADDR <= '0;
      OUTBUFWDATA <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      nOUTBUFWCLKEN <= ~(run & ~ABORT & pos < 14'(POS_LIMIT));
      OUTBUFWADDR <= wr_addr(pos[12:0], ch);
      OUTBUFWDATA <= bit_out;
      BUSY <= (fill | run) & ~ABORT;
      DONE <= state == ST_FINISH & ~ABORT;
      nreq <= nreq + 16'(take);
      if (run) begin
        ch <= ~ch;
        pos <= pos + 14'(ch);
      end
      if (ABORT & state != ST_IDLE) state <= ST_IDLE;
      else if (state == ST_IDLE & LOADSTART) begin
        state <= ST_FILL;
        pos <= LOADTYPE == LT_USER ? 14'(USER_BASE) : 14'(BOOT_BASE);
        bytes_l <= LOADTYPE == LT_USER ? 16'(USER_BYTES) : 16'(BOOT_BYTES);
        ch <= 1'b0;
        nreq <= '0;
      end else if (fill & take) state <= ST_RUN;
      else if (last & ~avail) state <= more ? ST_FILL : ST_FINISH;
      else if (state == ST_FINISH) state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_bubble_page_loader.sv
// tb_bubble_page_loader: scoreboard bench for bubble_page_loader
module tb_bubble_page_loader;
  logic MCLK = 1'b0, RST = 1'b1, LOADSTART = 1'b0, LOADSTART_b = 1'b0, LOADTYPE = 1'b0, ABORT = 1'b0, DINVALID = 1'b0;
  logic [7:0] DIN = '0;
  logic DINREADY, nOUTBUFWCLKEN, OUTBUFWDATA, BUSY, DONE;
  logic DINREADY_b, nOUTBUFWCLKEN_b, OUTBUFWDATA_b, BUSY_b, DONE_b;
  logic [14:0] OUTBUFWADDR, OUTBUFWADDR_b;
  int tests = 0, fails = 0, cyc_n = 0, ls_cyc = 0, done_cyc = 0, done_cnt = 0, strobes = 0;
  int byte_idx = 0, bit_idx = 0, base_m = 0, gap = 0, t = 0, n = 0;
  bit sel = 0, feed = 0, pend_hs = 0, user_pat = 0;
  logic [15:0] exp_q[$];
  logic [14:0] last_addr = '0;
  logic [7:0] first8 = '0;

  always #5 MCLK = ~MCLK;

  bubble_page_loader dut (
    .MCLK(MCLK), .RST(RST), .LOADSTART(LOADSTART), .LOADTYPE(LOADTYPE), .ABORT(ABORT),
    .DIN(DIN), .DINVALID(DINVALID), .DINREADY(DINREADY), .nOUTBUFWCLKEN(nOUTBUFWCLKEN),
    .OUTBUFWADDR(OUTBUFWADDR), .OUTBUFWDATA(OUTBUFWDATA), .BUSY(BUSY), .DONE(DONE)
  );

  bubble_page_loader #(.USER_BASE(8188), .USER_BYTES(2)) dut_b (
    .MCLK(MCLK), .RST(RST), .LOADSTART(LOADSTART_b), .LOADTYPE(LOADTYPE), .ABORT(ABORT),
    .DIN(DIN), .DINVALID(DINVALID), .DINREADY(DINREADY_b), .nOUTBUFWCLKEN(nOUTBUFWCLKEN_b),
    .OUTBUFWADDR(OUTBUFWADDR_b), .OUTBUFWDATA(OUTBUFWDATA_b), .BUSY(BUSY_b), .DONE(DONE_b)
  );

  function automatic logic [7:0] pat(input int i);
    return user_pat ? (i == 0 ? 8'hA5 : 8'((i * 37) + 11)) : 8'(i % 222);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model: bit i of the load goes to position base+i/2, channel i%2; positions >= 8190 are never written
  task automatic push_byte();
    logic [7:0] b;
    b = pat(byte_idx);
    byte_idx++;
    for (int k = 7; k >= 0; k--) begin
      int p;
      p = base_m + bit_idx / 2;
      if (p < 8190) exp_q.push_back({1'b0, 13'(p), 1'(bit_idx % 2), b[k]});
      bit_idx++;
    end
  endtask

  task automatic tick();
    logic s, d;
    logic [14:0] a;
    pend_hs = DINVALID & (sel ? DINREADY_b : DINREADY) & ~ABORT & ~RST;
    @(posedge MCLK);
    cyc_n++;
    @(negedge MCLK);
    if (pend_hs) push_byte();
    s = sel ? nOUTBUFWCLKEN_b : nOUTBUFWCLKEN;
    a = sel ? OUTBUFWADDR_b : OUTBUFWADDR;
    d = sel ? OUTBUFWDATA_b : OUTBUFWDATA;
    if (!s) begin
      strobes++;
      if (strobes <= 8) first8 = {first8[6:0], d};
      last_addr = a;
      if (exp_q.size() == 0) check("strobe_no_data", {16'h0, a, d}, 32'h10000);
      else check("write", {16'h0, a, d}, {16'h0, exp_q.pop_front()});
    end
    if (sel ? DONE_b : DONE) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    DINVALID = feed & (gap == 0 || cyc_n % 4 == 0);
    DIN = pat(byte_idx);
  endtask

  task automatic start(input logic typ, input int base, input bit b_sel);
    sel = b_sel;
    base_m = base;
    bit_idx = 0;
    byte_idx = 0;
    exp_q.delete();
    strobes = 0;
    done_cnt = 0;
    first8 = '0;
    feed = 1;
    LOADTYPE = typ;
    if (b_sel) LOADSTART_b = 1'b1;
    else LOADSTART = 1'b1;
    tick();
    ls_cyc = cyc_n;
    LOADSTART = 1'b0;
    LOADSTART_b = 1'b0;
  endtask

  task automatic finish_load(input int limit, input int pulse_every, input int exp_strobes,
                             input logic [14:0] exp_last, input int exp_len);
    int tt;
    tt = 0;
    while (done_cnt == 0 && tt < limit) begin
      if (pulse_every > 0) LOADSTART = (tt % pulse_every == 7);
      tick();
      tt++;
    end
    LOADSTART = 1'b0;
    check("done_seen", done_cnt, 1);
    check("busy_with_done", sel ? BUSY_b : BUSY, 0);
    check("strobe_count", strobes, exp_strobes);
    check("queue_drained", exp_q.size(), 0);
    check("last_addr", last_addr, exp_last);
    if (exp_len > 0) check("done_latency", done_cyc - ls_cyc, exp_len);
    feed = 0;
    tick();
    check("done_pulse_end", sel ? DONE_b : DONE, 0);
  endtask

  task automatic chk_reset(input string p);
    check({p, "_ready"}, DINREADY, 0);
    check({p, "_strobe"}, nOUTBUFWCLKEN, 1);
    check({p, "_addr"}, OUTBUFWADDR, 0);
    check({p, "_data"}, OUTBUFWDATA, 0);
    check({p, "_busy"}, BUSY, 0);
    check({p, "_done"}, DONE, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset("reset");
    RST = 1'b0;
    tick();
    // bootloader, stream held valid
    start(1'b0, 2053, 1'b0);
    check("start_busy_n", BUSY, 0);
    tick();
    check("start_busy", BUSY, 1);
    check("start_ready", DINREADY, 1);
    finish_load(5000, 0, 3824, 15'(3964 * 2 + 1), 3827);
    // user page, 0xA5 first, with ignored LOADSTART pulses while busy
    user_pat = 1;
    start(1'b1, 7168, 1'b0);
    LOADTYPE = 1'b0;
    finish_load(2000, 200, 1168, 15'(7751 * 2 + 1), 1171);
    check("user_first8", first8, 8'hA5);
    // user page with DINVALID 1-on/3-off
    gap = 1;
    start(1'b1, 7168, 1'b0);
    finish_load(8000, 0, 1168, 15'(7751 * 2 + 1), 0);
    check("gap_first8", first8, 8'hA5);
    gap = 0;
    // abort after 100 strobes, then restart from base
    user_pat = 0;
    start(1'b0, 2053, 1'b0);
    t = 0;
    while (strobes < 100 && t < 2000) begin
      tick();
      t++;
    end
    check("abort_reach", strobes, 100);
    ABORT = 1'b1;
    feed = 0;
    DINVALID = 1'b0;
    tick();
    ABORT = 1'b0;
    exp_q.delete();
    check("abort_strobe", nOUTBUFWCLKEN, 1);
    check("abort_busy", BUSY, 0);
    check("abort_ready", DINREADY, 0);
    repeat (20) tick();
    check("abort_strobes", strobes, 100);
    check("abort_no_done", done_cnt, 0);
    start(1'b0, 2053, 1'b0);
    finish_load(5000, 0, 3824, 15'(3964 * 2 + 1), 3827);
    // asynchronous reset in the middle of a run
    user_pat = 1;
    start(1'b1, 7168, 1'b0);
    repeat (300) tick();
    exp_q.delete();
    #2 RST = 1'b1;
    #1 chk_reset("midrst");
    n = strobes;
    repeat (5) tick();
    RST = 1'b0;
    feed = 0;
    repeat (5) tick();
    check("midrst_no_strobe", strobes, n);
    check("midrst_idle", BUSY, 0);
    // page running into reserved positions
    user_pat = 0;
    start(1'b1, 8188, 1'b1);
    finish_load(200, 0, 4, 15'(8189 * 2 + 1), 19);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
